// File: rtl/nixie_scan_n_if.sv
// Display-side bundle for the N-digit scanner: packed value, decimal points and
// blanking control in; digit select, segments and frame marker out.
interface nixie_scan_n_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] count;
    logic [DIGITS-1:0]   dp_sel;
    logic                blank_en;
    logic [DIGITS-1:0]   an;
    logic [7:0]          leds;
    logic                frame_start;

    modport master (
        output count, dp_sel, blank_en,
        input  an, leds, frame_start
    );

    modport slave (
        input  count, dp_sel, blank_en,
        output an, leds, frame_start
    );
endinterface

// File: rtl/nixie_scan_n.sv
// N-digit multiplexed 7-segment scanner with leading-zero blanking, per-digit
// decimal points, selectable output polarity and frame-coherent input capture.
module nixie_scan_n #(
    parameter int DIGITS      = 4,
    parameter int DIV         = 1000,
    parameter int AN_ACT_LOW  = 0,
    parameter int SEG_ACT_LOW = 0
) (
    input  logic            clk,
    input  logic            reset,
    nixie_scan_n_if.slave   bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_POL  = (AN_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]        SEG_POL = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_RST  = DIGITS'(1) ^ AN_POL;
    localparam logic [7:0]        LED_RST = 8'h3F ^ SEG_POL;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] cnt_s_q, cnt_s_d;
    logic [DIGITS-1:0]   dp_s_q, dp_s_d;
    logic                blk_s_q, blk_s_d;
    logic                load_pend_q, load_pend_d;
    logic                frame_start_q, frame_start_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          leds_q, leds_d;

    logic                tick;
    logic                last_digit;
    logic                load;
    logic [DIGITS-1:0]   blank_v;
    logic                zero_run;
    logic [3:0]          nib;
    logic [6:0]          seg;

    always_comb begin
        tick          = (pcnt_q == PW'(DIV - 1));
        last_digit    = (idx_q == IW'(DIGITS - 1));
        load          = load_pend_q | (tick & last_digit);
        pcnt_d        = tick ? '0 : pcnt_q + PW'(1);
        idx_d         = idx_q;
        if (tick) idx_d = last_digit ? '0 : idx_q + IW'(1);
        load_pend_d   = 1'b0;
        frame_start_d = load;
        cnt_s_d       = load ? bus.count    : cnt_s_q;
        dp_s_d        = load ? bus.dp_sel   : dp_s_q;
        blk_s_d       = load ? bus.blank_en : blk_s_q;
    end

    // Outputs follow the next-state index and shadow so a new frame's first
    // digit already shows the freshly captured value.
    always_comb begin
        blank_v  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (cnt_s_d[4*i +: 4] == 4'h0);
            if (i != 0) blank_v[i] = blk_s_d & zero_run;
        end
        nib    = cnt_s_d[4*int'(idx_d) +: 4];
        seg    = blank_v[idx_d] ? 7'h00 : glyph(nib);
        leds_d = {dp_s_d[idx_d], seg} ^ SEG_POL;
        an_d   = (DIGITS'(1) << idx_d) ^ AN_POL;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q        <= '0;
            idx_q         <= '0;
            cnt_s_q       <= '0;
            dp_s_q        <= '0;
            blk_s_q       <= 1'b0;
            load_pend_q   <= 1'b1;
            frame_start_q <= 1'b0;
            an_q          <= AN_RST;
            leds_q        <= LED_RST;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            cnt_s_q       <= cnt_s_d;
            dp_s_q        <= dp_s_d;
            blk_s_q       <= blk_s_d;
            load_pend_q   <= load_pend_d;
            frame_start_q <= frame_start_d;
            an_q          <= an_d;
            leds_q        <= leds_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.leds        = leds_q;
    assign bus.frame_start = frame_start_q;
endmodule
